// File: rtl/ascii_bcd_pkg.sv
// Shared definitions for the ASCII-to-packed-BCD packer.
//   ASCII_ZERO / ASCII_NINE : inclusive range of decimal digit characters
//   ASCII_SPACE             : character that can be skipped (ASCII_BCD_SKIP_SPACE_EN)
//   state_e                 : packer FSM states
//   char_class_t            : classification of one incoming character
package ascii_bcd_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2
  } state_e;

  typedef struct packed {
    logic       is_digit;
    logic       is_space;
    logic [3:0] nibble;   // digit value, 4'h0 for any non-digit
  } char_class_t;

endpackage

// File: rtl/ascii_bcd_packer_if.sv
// Byte-in / BCD-word-out stream bundle for ascii_bcd_packer.
//   master : upstream byte source plus downstream word sink (drives in_*, out_ready)
//   slave  : the packer (drives in_ready, out_*)
// Handshake: a beat transfers on a rising clk edge where valid & ready are both 1.
// valid must not depend on ready; once raised, the producer holds valid and the
// payload stable until the transfer happens. ready may change freely.
interface ascii_bcd_packer_if #(
  parameter int DIGITS = 4
);
  localparam int CNT_W = $clog2(DIGITS + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            in_char;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic [CNT_W-1:0]      out_count;
  logic                  out_err;

  modport master (
    output in_valid, in_char, in_last, out_ready,
    input  in_ready, out_valid, out_bcd, out_count, out_err
  );

  modport slave (
    input  in_valid, in_char, in_last, out_ready,
    output in_ready, out_valid, out_bcd, out_count, out_err
  );

endinterface

// File: rtl/ascii_digit_decode.sv
// Combinational ASCII character classifier.
//   char_i  : ASCII byte
//   class_o : {is_digit, is_space, nibble}; nibble is the digit value or 4'h0
module ascii_digit_decode
  import ascii_bcd_pkg::*;
(
  input  logic [7:0]  char_i,
  output char_class_t class_o
);

  always_comb begin
    class_o          = '0;
    class_o.is_digit = (char_i >= ASCII_ZERO) && (char_i <= ASCII_NINE);
    class_o.is_space = (char_i == ASCII_SPACE);
    // '0'..'9' are 0x30..0x39, so the low nibble is already the digit value.
    class_o.nibble   = class_o.is_digit ? char_i[3:0] : 4'h0;
  end

endmodule

// File: rtl/ascii_bcd_packer.sv
// Streaming ASCII-to-packed-BCD converter. Accepts one ASCII byte per beat,
// shifts digits into a DIGITS-nibble word (first char ends up in the most
// significant used nibble, short words right-aligned) and emits the word with
// its character count and a sticky non-digit error flag.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   bus     : ascii_bcd_packer_if.slave (in_* byte stream, out_* word stream)
//   state_o : current FSM state, for observation
// Optional feature: define ASCII_BCD_SKIP_SPACE_EN to accept 0x20 without
// packing it (no shift, no count, no error); in_last on a space still closes
// a non-empty word, and an empty word is simply dropped.
module ascii_bcd_packer
  import ascii_bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  ascii_bcd_packer_if.slave   bus,
  output state_e              state_o
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);

`ifdef ASCII_BCD_SKIP_SPACE_EN
  localparam bit SKIP_SPACE = 1'b1;
`else
  localparam bit SKIP_SPACE = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [W-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q,   err_d;

  char_class_t      cls;
  logic             accept;
  logic             skip_char;

  ascii_digit_decode u_decode (
    .char_i  (bus.in_char),
    .class_o (cls)
  );

  // No bypass: while a word is pending nothing new is accepted.
  assign accept    = bus.in_valid && (state_q != ST_EMIT);
  assign skip_char = SKIP_SPACE && cls.is_space;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (accept) begin
          if (skip_char) begin
            // A space closes the word only if something was packed.
            if (bus.in_last) begin
              state_d = (count_q != '0) ? ST_EMIT : ST_IDLE;
            end
          end else begin
            shift_d = W'(shift_q << 4) | W'(cls.nibble);
            count_d = count_q + CNT_W'(1);
            err_d   = err_q | ~cls.is_digit;
            // Reaching DIGITS chars closes the word whether or not in_last is set.
            if (bus.in_last || (count_q == CNT_W'(DIGITS - 1))) begin
              state_d = ST_EMIT;
            end else begin
              state_d = ST_COLLECT;
            end
          end
        end
      end
      ST_EMIT: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
          shift_d = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        shift_d = '0;
        count_d = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Outputs come straight from registers, so they are stable throughout EMIT.
  assign bus.in_ready  = (state_q != ST_EMIT);
  assign bus.out_valid = (state_q == ST_EMIT);
  assign bus.out_bcd   = shift_q;
  assign bus.out_count = count_q;
  assign bus.out_err   = err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_ascii_bcd_packer.sv
module tb_ascii_bcd_packer;
  import ascii_bcd_pkg::*;

  localparam int DIGITS = 4;
  localparam int EW     = 16 + 3 + 1;   // {bcd, count, err}

`ifdef ASCII_BCD_SKIP_SPACE_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic   clk;
  logic   rst;
  state_e state;

  ascii_bcd_packer_if #(.DIGITS(DIGITS)) bus ();

  ascii_bcd_packer #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

  logic [EW-1:0] exp_q[$];
  logic [7:0]    word_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic void model_emit();
    logic [15:0] bcd;
    logic        err;
    bcd = '0;
    err = 1'b0;
    foreach (word_q[i]) begin
      if (word_q[i] >= 8'h30 && word_q[i] <= 8'h39) begin
        bcd = bcd * 16 + 16'(word_q[i] - 8'h30);
      end else begin
        bcd = bcd * 16;
        err = 1'b1;
      end
    end
    exp_q.push_back({bcd, 3'(word_q.size()), err});
    word_q.delete();
  endfunction

  function automatic void model_accept(input logic [7:0] c, input bit l);
    if (SKIP && c == 8'h20) begin
      if (l && word_q.size() > 0) model_emit();
    end else begin
      word_q.push_back(c);
      if (l || word_q.size() == DIGITS) model_emit();
    end
  endfunction

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic send(input logic [7:0] c, input bit l);
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    bus.in_last  = l;
    for (int k = 0; k < 200; k++) begin
      acc = bus.in_ready;       // in_ready depends only on state, stable here
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
    end
    if (acc) begin
      model_accept(c, l);
    end else begin
      chk("send_timeout", 32'd0, 32'd1);
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_char  = $urandom_range(0, 255);
    bus.in_last  = $urandom_range(0, 1);
  endtask

  task automatic send_str(input string s, input bit l);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i], l && (i == s.len() - 1));
    end
  endtask

  // Literal expectation: output must be valid at the first negedge after the final accept.
  task automatic check_lit(input string name, input logic [15:0] bcd,
                           input logic [2:0] cnt, input logic err);
    @(negedge clk);
    chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, "_bcd"},   32'(bus.out_bcd),   32'(bcd));
    chk({name, "_count"}, 32'(bus.out_count), 32'(cnt));
    chk({name, "_err"},   32'(bus.out_err),   32'(err));
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      chk("in_ready",  32'(bus.in_ready),  32'(exp_q.size() == 0));
      if (bus.out_valid && exp_q.size() != 0) begin
        chk("sb_bcd",   32'(bus.out_bcd),   32'(exp_q[0][EW-1:4]));
        chk("sb_count", 32'(bus.out_count), 32'(exp_q[0][3:1]));
        chk("sb_err",   32'(bus.out_err),   32'(exp_q[0][0]));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;
    bus.in_last  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_bcd",       32'(bus.out_bcd),   32'd0);
    chk("rst_count",     32'(bus.out_count), 32'd0);
    chk("rst_err",       32'(bus.out_err),   32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // back-to-back full word
    ready_mode = 1;
    send_str("1234", 1'b0);
    check_lit("w1234", 16'h1234, 3'd4, 1'b0);

    // short word right-aligned
    send_str("97", 1'b1);
    check_lit("w97", 16'h0097, 3'd2, 1'b0);

    // non-digit flagged, error does not leak into next word
    send_str("1A34", 1'b0);
    check_lit("w1A34", 16'h1034, 3'd4, 1'b1);
    send_str("5555", 1'b0);
    check_lit("w5555", 16'h5555, 3'd4, 1'b0);

    // single char with in_last
    send_str("7", 1'b1);
    check_lit("w7", 16'h0007, 3'd1, 1'b0);

    // in_last on the 4th char has no extra effect
    send_str("8642", 1'b1);
    check_lit("w8642", 16'h8642, 3'd4, 1'b0);

    // backpressure: word held while the next char waits
    ready_mode = 0;
    send_str("1234", 1'b0);
    check_lit("hold", 16'h1234, 3'd4, 1'b0);
    fork
      send("5", 1'b0);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
          chk("hold_bcd",      32'(bus.out_bcd),  32'h1234);
        end
        ready_mode = 1;
      end
    join
    send_str("678", 1'b0);
    check_lit("w5678", 16'h5678, 3'd4, 1'b0);

    // reset mid-word discards it
    send_str("12", 1'b0);
    @(negedge clk);
    chk_en = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready),  32'd1);
    chk("mid_rst_bcd",   32'(bus.out_bcd),   32'd0);
    chk("mid_rst_count", 32'(bus.out_count), 32'd0);
    rst = 1'b0;
    word_q.delete();
    exp_q.delete();
    chk_en = 1'b1;
    send_str("3456", 1'b0);
    check_lit("w3456", 16'h3456, 3'd4, 1'b0);

    // space handling
    send_str("1 2", 1'b1);
`ifdef ASCII_BCD_SKIP_SPACE_EN
    check_lit("space", 16'h0012, 3'd2, 1'b0);
    send_str(" ", 1'b1);       // empty word dropped: nothing emitted
`else
    check_lit("space", 16'h0102, 3'd3, 1'b1);
`endif

    // randomized traffic
    ready_mode = 2;
    for (int n = 0; n < 400; n++) begin
      int          r;
      logic [7:0]  c;
      r = $urandom_range(0, 9);
      if (r <= 5)      c = 8'h30 + 8'($urandom_range(0, 9));
      else if (r == 6) c = 8'h20;
      else if (r == 7) c = 8'h41;
      else             c = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      send(c, ($urandom_range(0, 4) == 0));
    end
    send("9", 1'b1);

    // drain
    ready_mode = 1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
